stream_demux: RTL and testbench

- Valid/ready stream demultiplexer: the inverse of the mux primitive.
- Routes each accepted upstream word to exactly one of N downstream channels, chosen by a per-word select.
- Each channel has a one-entry output register.
- Sits after the serial source in datapath exercises, feeding per-lane consumers, and counts accepted words.

---
 rtl/stream_demux_pkg.sv | 15 +
 rtl/stream_demux_slot.sv | 38 +++
 rtl/stream_demux.sv | 85 ++++++++
 tb/tb_stream_demux.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared defaults and helpers for the stream demultiplexer.
package stream_demux_pkg;

  localparam int N_DEF     = 4;
  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 16;

  // Select width never drops to zero, even for a single-channel build.
  function automatic int sel_width(input int n);
    int s;
    s = $clog2(n);
    return (s < 1) ? 1 : s;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One downstream channel: a full flag plus a one-entry data register.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         full;
  logic [W-1:0] data_q;
  logic         consume;

  assign consume = full & ready;

  // A load in the same cycle as a consume keeps the slot full with new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (load) begin
      full   <= 1'b1;
      data_q <= load_data;
    end else if (consume) begin
      full   <= 1'b0;
    end
  end

  assign valid = full;
  assign data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Valid/ready 1-to-N demultiplexer with per-channel output registers.
// Optional even-parity checking is enabled by defining STREAM_DEMUX_PARITY_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int W     = W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [W-1:0]     up_data,
  input  logic [SEL_W-1:0] up_sel,
  input  logic             up_par,
  output logic [N-1:0]     down_valid,
  input  logic [N-1:0]     down_ready,
  output logic [N*W-1:0]   down_data,
  output logic             sel_err,
  output logic             par_err,
  output logic [CNT_W-1:0] word_cnt
);

  logic [N-1:0] sel_hit;
  logic [N-1:0] load;
  logic         sel_ok;
  logic         accept;

  // Out-of-range selects match no channel, so they are always accepted.
  always_comb begin
    sel_hit  = '0;
    sel_ok   = 1'b0;
    up_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (up_sel == SEL_W'(i)) begin
        sel_hit[i] = 1'b1;
        sel_ok     = 1'b1;
        up_ready   = ~down_valid[i] | down_ready[i];
      end
    end
  end

  assign accept = up_valid & up_ready;
  assign load   = sel_hit & {N{accept}};

  for (genvar g = 0; g < N; g++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .ready     (down_ready[g]),
      .load_data (up_data),
      .valid     (down_valid[g]),
      .data      (down_data[g*W +: W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      sel_err  <= 1'b0;
    end else begin
      sel_err <= accept & ~sel_ok;
      if (accept & sel_ok) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

`ifdef STREAM_DEMUX_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (rst) par_err_q <= 1'b0;
    else if (accept && (^{up_data, up_par})) par_err_q <= 1'b1;
  end

  assign par_err = par_err_q;
`else
  logic unused_par;
  assign unused_par = up_par;
  assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: 4-channel scoreboard instance plus a
// 3-channel, 4-bit-counter instance for invalid-select and wrap cases.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A: N=4, W=8, CNT_W=16
  logic        up_valid_a, up_ready_a, up_par_a;
  logic [7:0]  up_data_a;
  logic [1:0]  up_sel_a;
  logic [3:0]  down_valid_a, down_ready_a;
  logic [31:0] down_data_a;
  logic        sel_err_a, par_err_a;
  logic [15:0] word_cnt_a;

  // instance B: N=3, W=8, CNT_W=4
  logic        up_valid_b, up_ready_b, up_par_b;
  logic [7:0]  up_data_b;
  logic [1:0]  up_sel_b;
  logic [2:0]  down_valid_b, down_ready_b;
  logic [23:0] down_data_b;
  logic        sel_err_b, par_err_b;
  logic [3:0]  word_cnt_b;

  stream_demux #(.N(4), .W(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .up_valid(up_valid_a), .up_ready(up_ready_a), .up_data(up_data_a),
    .up_sel(up_sel_a), .up_par(up_par_a),
    .down_valid(down_valid_a), .down_ready(down_ready_a), .down_data(down_data_a),
    .sel_err(sel_err_a), .par_err(par_err_a), .word_cnt(word_cnt_a)
  );

  stream_demux #(.N(3), .W(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .up_valid(up_valid_b), .up_ready(up_ready_b), .up_data(up_data_b),
    .up_sel(up_sel_b), .up_par(up_par_b),
    .down_valid(down_valid_b), .down_ready(down_ready_b), .down_data(down_data_b),
    .sel_err(sel_err_b), .par_err(par_err_b), .word_cnt(word_cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  q_a [4][$];
  logic [15:0] cnt_m;
  logic        acc_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on instance A: compare against the scoreboard, then advance it.
  task automatic tick_a();
    logic [3:0] full_m;
    logic       exp_ready;
    #1;
    for (int i = 0; i < 4; i++) full_m[i] = (q_a[i].size() != 0);
    check("down_valid_a", 32'(down_valid_a), 32'(full_m));
    check("word_cnt_a", 32'(word_cnt_a), 32'(cnt_m));
    exp_ready = ~full_m[up_sel_a] | down_ready_a[up_sel_a];
    check("up_ready_a", 32'(up_ready_a), 32'(exp_ready));
    for (int i = 0; i < 4; i++) begin
      if (full_m[i] && down_ready_a[i]) begin
        check("down_data_a", 32'(down_data_a[i*8 +: 8]), 32'(q_a[i][0]));
        void'(q_a[i].pop_front());
      end
    end
    acc_a = up_valid_a & exp_ready;
    if (acc_a) begin
      q_a[up_sel_a].push_back(up_data_a);
      cnt_m = cnt_m + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up_valid_a = 1'b1; up_valid_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    up_valid_a = 1'b0; up_valid_b = 1'b0;
    for (int i = 0; i < 4; i++) q_a[i].delete();
    cnt_m = '0;
  endtask

  initial begin
    rst = 1'b1;
    up_data_a = 8'h00; up_sel_a = 2'd0; up_par_a = 1'b0; down_ready_a = 4'h0;
    up_data_b = 8'h00; up_sel_b = 2'd0; up_par_b = 1'b0; down_ready_b = 3'h0;
    acc_a = 1'b0;
    @(negedge clk);

    // reset with upstream asserting valid
    do_reset();
    #1;
    check("rst_down_valid_a", 32'(down_valid_a), 32'h0);
    check("rst_word_cnt_a", 32'(word_cnt_a), 32'h0);
    check("rst_sel_err_a", 32'(sel_err_a), 32'h0);
    check("rst_par_err_a", 32'(par_err_a), 32'h0);
    check("rst_down_valid_b", 32'(down_valid_b), 32'h0);
    check("rst_word_cnt_b", 32'(word_cnt_b), 32'h0);

    // routing: 0xA5 to channel 2 with all consumers stalled
    up_valid_a = 1'b1; up_data_a = 8'hA5; up_sel_a = 2'd2; up_par_a = ^8'hA5;
    tick_a();
    check("route_valid", 32'(down_valid_a), 32'h4);
    check("route_data", 32'(down_data_a[23:16]), 32'hA5);
    check("route_cnt", 32'(word_cnt_a), 32'd1);

    // back-pressure: channel 2 full, 0x3C held
    up_data_a = 8'h3C; up_par_a = ^8'h3C;
    tick_a();
    up_sel_a = 2'd1;
    #1;
    check("bp_ready_sel1", 32'(up_ready_a), 32'h1);
    up_sel_a = 2'd2;

    // drain and load channel 2 in the same cycle: no bubble
    down_ready_a = 4'b0100;
    tick_a();
    down_ready_a = 4'b0000;
    up_valid_a = 1'b0;
    #1;
    check("pass_valid2", 32'(down_valid_a[2]), 32'h1);
    check("pass_data2", 32'(down_data_a[23:16]), 32'h3C);

    // randomized traffic, holding each word stable until accepted
    for (int k = 0; k < 60; k++) begin
      if (!up_valid_a || acc_a) begin
        up_valid_a = 1'($urandom_range(0, 1));
        up_data_a  = 8'($urandom);
        up_sel_a   = 2'($urandom_range(0, 3));
        up_par_a   = ^up_data_a;
      end
      down_ready_a = 4'($urandom);
      tick_a();
    end

    // drain everything
    up_valid_a = 1'b0;
    down_ready_a = 4'hF;
    repeat (3) tick_a();
    check("drain_empty", 32'(down_valid_a), 32'h0);

    // invalid select on the 3-channel instance
    down_ready_b = 3'b000;
    up_valid_b = 1'b1; up_sel_b = 2'd3; up_data_b = 8'h5A; up_par_b = ^8'h5A;
    #1;
    check("inv_ready", 32'(up_ready_b), 32'h1);
    @(posedge clk); @(negedge clk);
    up_valid_b = 1'b0;
    #1;
    check("inv_sel_err", 32'(sel_err_b), 32'h1);
    check("inv_cnt", 32'(word_cnt_b), 32'h0);
    check("inv_valid", 32'(down_valid_b), 32'h0);
    @(posedge clk); @(negedge clk);
    #1;
    check("inv_sel_err_pulse", 32'(sel_err_b), 32'h0);

    // counter wrap: 17 words into a 4-bit counter
    down_ready_b = 3'b111;
    up_valid_b = 1'b1; up_sel_b = 2'd0;
    for (int k = 0; k < 17; k++) begin
      up_data_b = 8'(k); up_par_b = ^up_data_b;
      @(posedge clk); @(negedge clk);
    end
    up_valid_b = 1'b0;
    #1;
    check("wrap_cnt", 32'(word_cnt_b), 32'd1);
    check("wrap_last_data", 32'(down_data_b[7:0]), 32'd16);

    // parity: 0x01 with up_par=0 has odd overall parity
    down_ready_a = 4'h0;
    up_valid_a = 1'b1; up_data_a = 8'h01; up_sel_a = 2'd0; up_par_a = 1'b0;
    tick_a();
    up_valid_a = 1'b0;
    down_ready_a = 4'h1;
    tick_a();
`ifdef STREAM_DEMUX_PARITY_EN
    check("par_set", 32'(par_err_a), 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("par_sticky", 32'(par_err_a), 32'h1);
    do_reset();
    #1;
    check("par_cleared", 32'(par_err_a), 32'h0);
`else
    check("par_disabled", 32'(par_err_a), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
